// File: rtl/bfp16_pkg.sv
// Shared BFP16 types, constants and classification helpers for the stream accumulator.
package bfp16_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccept = 2'd1,
    StAdd    = 2'd2,
    StDone   = 2'd3
  } state_e;

  localparam logic [7:0]  BFP16_EXP_MAX = 8'hFF;
  localparam logic [31:0] POS_ZERO      = 32'h0000_0000;
  localparam logic [31:0] BFP16_MASK    = 32'hFFFF_0000;

  function automatic logic is_inf(input logic [31:0] w);
    return (w[30:23] == BFP16_EXP_MAX) && (w[22:0] == 23'h0);
  endfunction

  function automatic logic is_nan(input logic [31:0] w);
    return (w[30:23] == BFP16_EXP_MAX) && (w[22:0] != 23'h0);
  endfunction

endpackage

// File: rtl/BFP16_add.sv
// Combinational BFP16 adder on the upper 16 bits of two FP32 containers.
// Subnormals flush to zero, round-to-nearest-even, NaN results are canonical 0x7FC0.
module BFP16_add
  import bfp16_pkg::*;
#(
  parameter int unsigned SIZE_DATA = 32
) (
  input  logic [SIZE_DATA-1:0] i_a,
  input  logic [SIZE_DATA-1:0] i_b,
  output logic [SIZE_DATA-1:0] o_s
);

  logic [15:0]       a, b, big, sml, res;
  logic [10:0]       mb, ms, ms_al;
  logic [11:0]       s;
  logic [7:0]        d, man;
  logic [8:0]        man9;
  logic signed [9:0] e;
  logic              sticky, rnd;

  logic unused_lo;
  assign unused_lo = ^{i_a[SIZE_DATA-17:0], i_b[SIZE_DATA-17:0]};

  always_comb begin
    a      = i_a[SIZE_DATA-1 -: 16];
    b      = i_b[SIZE_DATA-1 -: 16];
    res    = 16'h0;
    big    = a;
    sml    = b;
    mb     = '0;
    ms     = '0;
    ms_al  = '0;
    d      = '0;
    s      = '0;
    e      = '0;
    man    = '0;
    man9   = '0;
    sticky = 1'b0;
    rnd    = 1'b0;
    if (is_nan({a, 16'h0}) || is_nan({b, 16'h0}) ||
        (is_inf({a, 16'h0}) && is_inf({b, 16'h0}) && (a[15] != b[15]))) begin
      res = 16'h7FC0;
    end else if (is_inf({a, 16'h0})) begin
      res = a;
    end else if (is_inf({b, 16'h0})) begin
      res = b;
    end else begin
      if (a[14:0] < b[14:0]) begin
        big = b;
        sml = a;
      end
      if (big[14:7] == 8'h00) begin
        res = {big[15] & sml[15], 15'h0};
      end else begin
        // 1.mmmmmmm followed by guard, round and sticky bits
        mb = {1'b1, big[6:0], 3'b000};
        ms = (sml[14:7] == 8'h00) ? 11'h0 : {1'b1, sml[6:0], 3'b000};
        d  = big[14:7] - sml[14:7];
        if (d >= 8'd11) begin
          ms_al = {10'h0, |ms};
        end else begin
          ms_al = ms >> d;
          for (int i = 0; i < 11; i++) begin
            if (i < int'(d)) sticky = sticky | ms[i];
          end
          ms_al[0] = ms_al[0] | sticky;
        end
        if (big[15] == sml[15]) s = {1'b0, mb} + {1'b0, ms_al};
        else                    s = {1'b0, mb} - {1'b0, ms_al};
        e = $signed({2'b00, big[14:7]});
        if (s == 12'h0) begin
          res = 16'h0;
        end else begin
          if (s[11]) begin
            s = {1'b0, s[11:2], s[1] | s[0]};
            e = e + 10'sd1;
          end
          for (int i = 0; i < 10; i++) begin
            if (!s[10]) begin
              s = s << 1;
              e = e - 10'sd1;
            end
          end
          man  = s[10:3];
          rnd  = s[2] & (s[1] | s[0] | s[3]);
          man9 = {1'b0, man} + {8'h0, rnd};
          if (man9[8]) begin
            man = man9[8:1];
            e   = e + 10'sd1;
          end else begin
            man = man9[7:0];
          end
          if (e <= 10'sd0)        res = {big[15], 15'h0};
          else if (e >= 10'sd255) res = {big[15], BFP16_EXP_MAX, 7'h0};
          else                    res = {big[15], e[7:0], man[6:0]};
        end
      end
    end
  end

  assign o_s = {res, {(SIZE_DATA-16){1'b0}}};

endmodule

// File: rtl/bfp16_stream_accum.sv
// Streams BFP16 operands (upper half of each word) into a running sum and returns the
// job total on a valid/ready port; one operand is folded in every two cycles.
module bfp16_stream_accum
  import bfp16_pkg::*;
#(
  parameter int unsigned SIZE_DATA = 32,
  parameter int unsigned SIZE_CNT  = 10
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [SIZE_CNT:0]    i_len,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  input  logic [SIZE_DATA-1:0] i_in_data,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic [SIZE_DATA-1:0] o_out_data,
  output logic                 o_busy,
  output logic [SIZE_CNT:0]    o_count,
  output logic                 o_ov_flow,
  output logic                 o_nan
);

  state_e               state_q, state_d;
  logic [SIZE_DATA-1:0] acc_q, acc_d, opnd_q, opnd_d, sum;
  logic [SIZE_CNT:0]    cnt_q, cnt_d, len_q, len_d, cnt_inc;
  logic                 ov_q, ov_d, nan_q, nan_d;

  BFP16_add #(
    .SIZE_DATA(SIZE_DATA)
  ) u_add (
    .i_a(acc_q),
    .i_b(opnd_q),
    .o_s(sum)
  );

  assign cnt_inc = cnt_q + {{SIZE_CNT{1'b0}}, 1'b1};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ov_d    = ov_q;
    nan_d   = nan_q;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          len_d   = i_len;
          acc_d   = POS_ZERO;
          cnt_d   = '0;
          ov_d    = 1'b0;
          nan_d   = 1'b0;
          state_d = (i_len == '0) ? StDone : StAccept;
        end
      end
      StAccept: begin
        if (i_in_valid) begin
          opnd_d  = i_in_data & BFP16_MASK;
          state_d = StAdd;
        end
      end
      StAdd: begin
        acc_d = sum;
        cnt_d = cnt_inc;
        // Overflow only counts when the infinity was created here, not propagated in
        if (is_inf(sum) && !is_inf(acc_q) && !is_inf(opnd_q)) ov_d = 1'b1;
        if (is_nan(sum)) nan_d = 1'b1;
        state_d = (cnt_inc == len_q) ? StDone : StAccept;
      end
      StDone: begin
        if (i_out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      acc_q   <= POS_ZERO;
      opnd_q  <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      ov_q    <= 1'b0;
      nan_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ov_q    <= ov_d;
      nan_q   <= nan_d;
    end
  end

  assign o_in_ready  = (state_q == StAccept);
  assign o_out_valid = (state_q == StDone);
  assign o_out_data  = (state_q == StDone) ? (acc_q & BFP16_MASK) : '0;
  assign o_busy      = (state_q != StIdle);
  assign o_count     = cnt_q;
  assign o_ov_flow   = ov_q;
  assign o_nan       = nan_q;

endmodule

// File: tb/tb_bfp16_stream_accum.sv
// Directed bench for bfp16_stream_accum: vector table of whole jobs plus hand-written
// timing, backpressure and mid-job reset sequences.
module tb_bfp16_stream_accum;

  logic        clk = 1'b0;
  logic        i_rst, i_start, i_in_valid, i_out_ready;
  logic [10:0] i_len;
  logic [31:0] i_in_data;
  logic        o_in_ready, o_out_valid, o_busy, o_ov_flow, o_nan;
  logic [31:0] o_out_data;
  logic [10:0] o_count;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bfp16_stream_accum #(
    .SIZE_DATA(32),
    .SIZE_CNT (10)
  ) dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_len      (i_len),
    .i_in_valid (i_in_valid),
    .o_in_ready (o_in_ready),
    .i_in_data  (i_in_data),
    .o_out_valid(o_out_valid),
    .i_out_ready(i_out_ready),
    .o_out_data (o_out_data),
    .o_busy     (o_busy),
    .o_count    (o_count),
    .o_ov_flow  (o_ov_flow),
    .o_nan      (o_nan)
  );

  typedef struct {
    logic [10:0]      len;
    logic [3:0][31:0] ops;
    logic [31:0]      sum;
    logic             ov;
    logic             nan;
  } vec_t;

  vec_t vecs[9];

  function automatic vec_t mk(input int len, input logic [31:0] o0, input logic [31:0] o1,
                              input logic [31:0] o2, input logic [31:0] o3,
                              input logic [31:0] sum, input logic ov, input logic nan);
    vec_t v;
    v.len    = 11'(len);
    v.ops[0] = o0;
    v.ops[1] = o1;
    v.ops[2] = o2;
    v.ops[3] = o3;
    v.sum    = sum;
    v.ov     = ov;
    v.nan    = nan;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one whole job with valid held high, then completes the output handshake.
  task automatic run_job(input vec_t v, output logic [31:0] sum, output logic [10:0] cnt,
                         output logic ov, output logic nan, output int cyc,
                         output logic any_rdy);
    int   idx;
    logic hs;
    idx     = 0;
    cyc     = 0;
    any_rdy = 1'b0;
    i_len      = v.len;
    i_start    = 1'b1;
    i_in_valid = (v.len != 0);
    i_in_data  = v.ops[0];
    tick();
    i_start = 1'b0;
    while (!o_out_valid && cyc < 100) begin
      any_rdy = any_rdy | o_in_ready;
      hs = o_in_ready & i_in_valid;
      tick();
      cyc++;
      if (hs) begin
        idx++;
        i_in_valid = (idx < int'(v.len));
        i_in_data  = v.ops[idx[1:0]];
      end
    end
    any_rdy = any_rdy | o_in_ready;
    check("job_timeout", {31'h0, o_out_valid}, 32'h1);
    sum = o_out_data;
    cnt = o_count;
    ov  = o_ov_flow;
    nan = o_nan;
    i_in_valid  = 1'b0;
    i_out_ready = 1'b1;
    tick();
    i_out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] sum;
    logic [10:0] cnt;
    logic        ov, nan, any_rdy, hs, seen_vld;
    logic [9:0]  rdy_v, vld_v;
    logic [31:0] bp_ops [3];
    int          cyc, acc, guard;

    i_rst = 1'b1; i_start = 1'b0; i_len = '0; i_in_valid = 1'b0;
    i_in_data = '0; i_out_ready = 1'b0;
    tick();
    tick();
    check("rst_busy",  {31'h0, o_busy},      32'h0);
    check("rst_ready", {31'h0, o_in_ready},  32'h0);
    check("rst_valid", {31'h0, o_out_valid}, 32'h0);
    check("rst_count", {21'h0, o_count},     32'h0);
    check("rst_data",  o_out_data,           32'h0);
    check("rst_ov",    {31'h0, o_ov_flow},   32'h0);
    check("rst_nan",   {31'h0, o_nan},       32'h0);
    i_rst = 1'b0;
    tick();

    vecs[0] = mk(4, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
                 32'h40800000, 1'b0, 1'b0);
    vecs[1] = mk(0, 32'h3F800000, 32'h0, 32'h0, 32'h0, 32'h00000000, 1'b0, 1'b0);
    vecs[2] = mk(2, 32'h3F80FFFF, 32'h40000001, 32'h0, 32'h0, 32'h40400000, 1'b0, 1'b0);
    vecs[3] = mk(2, 32'h7F7F0000, 32'h7F7F0000, 32'h0, 32'h0, 32'h7F800000, 1'b1, 1'b0);
    vecs[4] = mk(1, 32'h3F800000, 32'h0, 32'h0, 32'h0, 32'h3F800000, 1'b0, 1'b0);
    vecs[5] = mk(1, 32'h7FC00000, 32'h0, 32'h0, 32'h0, 32'h7FC00000, 1'b0, 1'b1);
    vecs[6] = mk(3, 32'h40000000, 32'hC0000000, 32'h3F000000, 32'h0,
                 32'h3F000000, 1'b0, 1'b0);
    vecs[7] = mk(2, 32'hBF800000, 32'h3F000000, 32'h0, 32'h0, 32'hBF000000, 1'b0, 1'b0);
    // 1+1/128 plus 1/256 is an exact tie; rounds to the even mantissa
    vecs[8] = mk(2, 32'h3F810000, 32'h3B800000, 32'h0, 32'h0, 32'h3F820000, 1'b0, 1'b0);

    for (int i = 0; i < 9; i++) begin
      run_job(vecs[i], sum, cnt, ov, nan, cyc, any_rdy);
      check($sformatf("v%0d_sum", i),   sum,                 vecs[i].sum);
      check($sformatf("v%0d_count", i), {21'h0, cnt},        {21'h0, vecs[i].len});
      check($sformatf("v%0d_ov", i),    {31'h0, ov},         {31'h0, vecs[i].ov});
      check($sformatf("v%0d_nan", i),   {31'h0, nan},        {31'h0, vecs[i].nan});
      check($sformatf("v%0d_cycles", i), 32'(cyc),           32'(2 * int'(vecs[i].len)));
      check($sformatf("v%0d_any_rdy", i), {31'h0, any_rdy},  {31'h0, vecs[i].len != 0});
      check($sformatf("v%0d_idle", i),  {31'h0, o_busy},     32'h0);
      check($sformatf("v%0d_ov_hold", i), {31'h0, o_ov_flow}, {31'h0, vecs[i].ov});
    end

    // Cycle-exact accept and completion pattern for a 4-operand job
    i_len = 11'd4; i_start = 1'b1; i_in_valid = 1'b1; i_in_data = 32'h3F800000;
    tick();
    i_start = 1'b0;
    for (int t = 0; t < 10; t++) begin
      rdy_v[t] = o_in_ready;
      vld_v[t] = o_out_valid;
      tick();
    end
    check("tim_ready", {22'h0, rdy_v}, 32'h0000_0055);
    check("tim_valid", {22'h0, vld_v}, 32'h0000_0300);
    check("tim_count", {21'h0, o_count}, 32'd4);
    check("tim_sum", o_out_data, 32'h40800000);
    i_in_valid = 1'b0; i_out_ready = 1'b1;
    tick();
    i_out_ready = 1'b0;

    // Backpressure: gapped input, stalled sink, stray start during DONE
    bp_ops[0] = 32'h40000000; bp_ops[1] = 32'hC0000000; bp_ops[2] = 32'h3F000000;
    i_len = 11'd3; i_start = 1'b1; i_in_valid = 1'b0;
    tick();
    i_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      repeat (3) tick();
      check($sformatf("bp_hold%0d", k), {21'h0, o_count}, 32'(k));
      i_in_valid = 1'b1;
      i_in_data  = bp_ops[k];
      guard = 0;
      hs    = 1'b0;
      while (!hs && guard < 20) begin
        hs = o_in_ready;
        tick();
        guard++;
      end
      check($sformatf("bp_accept%0d", k), {31'h0, hs}, 32'h1);
      i_in_valid = 1'b0;
    end
    guard = 0;
    while (!o_out_valid && guard < 20) begin
      tick();
      guard++;
    end
    for (int t = 0; t < 5; t++) begin
      check($sformatf("bp_data%0d", t), o_out_data, 32'h3F000000);
      check($sformatf("bp_valid%0d", t), {31'h0, o_out_valid}, 32'h1);
      i_start = (t == 2);
      i_len   = 11'd1;
      tick();
    end
    i_start = 1'b0;
    i_out_ready = 1'b1;
    tick();
    i_out_ready = 1'b0;
    check("bp_idle", {31'h0, o_busy}, 32'h0);
    tick();
    tick();
    check("bp_start_ignored", {31'h0, o_busy}, 32'h0);
    check("bp_count_held", {21'h0, o_count}, 32'd3);

    // Reset after two operands of a four-operand job
    i_len = 11'd4; i_start = 1'b1; i_in_valid = 1'b1; i_in_data = 32'h3F800000;
    tick();
    i_start = 1'b0;
    acc   = 0;
    guard = 0;
    while (acc < 2 && guard < 20) begin
      hs = o_in_ready & i_in_valid;
      tick();
      guard++;
      if (hs) acc++;
    end
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    i_in_valid = 1'b0;
    check("mid_rst_busy",  {31'h0, o_busy},     32'h0);
    check("mid_rst_ready", {31'h0, o_in_ready}, 32'h0);
    check("mid_rst_count", {21'h0, o_count},    32'h0);
    seen_vld = 1'b0;
    for (int t = 0; t < 8; t++) begin
      seen_vld = seen_vld | o_out_valid;
      tick();
    end
    check("mid_rst_no_valid", {31'h0, seen_vld}, 32'h0);
    run_job(mk(1, 32'h40400000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0),
            sum, cnt, ov, nan, cyc, any_rdy);
    check("post_rst_sum", sum, 32'h40400000);
    check("post_rst_count", {21'h0, cnt}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bfp16_stream_accum.md
Name: bfp16_stream_accum

Overview:
- Sequential receiver/consumer for an FP32-word operand stream of BFP16 values, carried in the upper 16 bits; lower 16 bits are ignored.
- Accumulates a job of i_len operands into a running sum using one instance of the team's combinational BFP16 adder.
- Returns the final sum on a valid/ready output port.
- Sits between a ROM/stream source and a result sink. This is the hardware counterpart of the bench-side "feed back o_32_s as next operand" running-sum loop.

Parameters:
SIZE_DATA, 32, word width (FP32 container; BFP16 = bits [31:16]).
SIZE_CNT, 10, job length counter width; max job length 2**SIZE_CNT.

Ports:
i_clk  input  1  clock, rising edge.
i_rst  input  1  synchronous active-high reset.
i_start  input  1  job start pulse; sampled only in IDLE.
i_len  input  SIZE_CNT+1  number of operands in job (0..2**SIZE_CNT); latched on accepted start.
i_in_valid  input  1  operand valid.
o_in_ready  output  1  operand ready.
i_in_data  input  SIZE_DATA  operand word.
o_out_valid  output  1  sum valid.
i_out_ready  input  1  sink ready.
o_out_data  output  SIZE_DATA  final sum; bits [15:0] always 0.
o_busy  output  1  high in any state except IDLE.
o_count  output  SIZE_CNT+1  operands accumulated so far in current job.
o_ov_flow  output  1  sticky per job: a partial sum reached +/-inf from finite operands.
o_nan  output  1  sticky per job: a partial sum was NaN.

Behaviour:
- Reset, synchronous, priority over everything:
  - state = IDLE.
  - Accumulator = 0x00000000; o_count = 0; latched length = 0.
  - o_in_ready = 0; o_out_valid = 0; o_busy = 0.
  - o_ov_flow = 0; o_nan = 0.
  - o_out_data = 0.
  - Reset mid-job discards all partial state; no output is produced for the aborted job.
- Operand truncation: operand register stores {i_in_data[31:16], 16'h0}.
- Adder: combinational sum of accumulator and operand register, SIZE_DATA=32. The adder result is registered; no path runs from any input to any output.
- FSM, Moore outputs:
  - IDLE:
    - o_in_ready = 0.
    - On i_start: latch i_len, clear accumulator/count/flags.
    - If i_len == 0, go to DONE (sum = +0.0). Otherwise go to ACCEPT.
  - ACCEPT:
    - o_in_ready = 1.
    - On i_in_valid & o_in_ready, capture the operand and go to ADD.
    - Otherwise hold.
  - ADD (exactly 1 cycle):
    - o_in_ready = 0.
    - Accumulator <= adder result; o_count++.
    - Set o_ov_flow if the result exponent is 0xFF with mantissa 0 and neither input was inf.
    - Set o_nan if the result exponent is 0xFF with mantissa != 0.
    - If the new count equals the latched length, go to DONE; otherwise go to ACCEPT.
  - DONE:
    - o_out_valid = 1; o_out_data = accumulator, stable while waiting.
    - On i_out_ready, go to IDLE. Flags and o_count hold until the next start.
- i_start outside IDLE is ignored. i_in_valid outside ACCEPT is ignored, with no capture.
- Throughput: 1 operand per 2 cycles. With start at cycle 0 and i_in_valid held high:
  - operand k is accepted at cycle 2k+1;
  - o_out_valid rises at cycle 2N+1.
- Accumulation order is strictly arrival order; rounding is whatever the adder defines per step.
- Length 2**SIZE_CNT must work: the counter is SIZE_CNT+1 wide, so there is no wrap.

Decomposition:
- Shared package bfp16_pkg holds:
  - state enum: IDLE, ACCEPT, ADD, DONE;
  - constants BFP16_EXP_MAX=8'hFF, POS_ZERO=32'h0, BFP16_MASK=32'hFFFF0000;
  - functions is_inf() and is_nan() on 32-bit words.
- Single sub-module: the existing combinational adder BFP16_add, instanced once.
- FSM, counter and handshake stay in this module.

Test Plan:
1. Basic sum: start, len=4, operands 0x3F800000 x4 with valid held high -> accepts at cycles 1,3,5,7; o_out_valid at cycle 9; o_out_data=0x40800000; o_count=4; flags 0.
2. Empty job: start, len=0 -> o_out_valid next cycle; o_out_data=0x00000000; o_in_ready never asserts.
3. Truncation: len=2, operands 0x3F80FFFF and 0x40000001 -> o_out_data=0x40400000 (3.0), bits [15:0] zero.
4. Backpressure:
   - len=3, operands 0x40000000, 0xC0000000, 0x3F000000;
   - i_in_valid has 3-cycle gaps; i_out_ready low for 5 cycles after DONE; i_start pulsed during DONE;
   - -> result 0x3F000000 held stable throughout; second start ignored; returns to IDLE only on ready.
5. Overflow/NaN:
   - len=2, operands 0x7F7F0000 x2 -> o_out_data=0x7F800000 and o_ov_flow=1; next job with 0x3F800000 clears it.
   - len=1 with 0x7FC00000 -> o_nan=1.
6. Reset mid-job: len=4, assert i_rst after 2 operands accepted -> next cycle o_busy=0, o_in_ready=0, o_count=0, o_out_valid never rises; a following len=1 job with 0x40400000 returns exactly 0x40400000.
